bram32k_reader: RTL and testbench

- Read-side counterpart of the layer writeback path.
- Fetches packed 64-bit feature-map words from the two BRAM32k ports at a common, incrementing address.
- Unpacks each word into eight signed 8-bit values, byte 0 (bits [7:0]) first.
- Streams lane A (port 1) and lane B (port 2) bytes in lockstep to the PE groups over a valid/ready handshake, with a 2-word prefetch so the stream has no bubbles.

---
 rtl/bram32k_reader.sv | 226 ++++++++++++++++++++++
 tb/tb_bram32k_reader.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram32k_reader.sv
// bram32k_reader
//
// Read-side counterpart of the layer writeback path. Fetches packed 64-bit
// feature-map words from the two BRAM32k ports at a shared, incrementing
// address. Each word is unpacked into eight raw bytes, byte 0 (bits [7:0])
// first. Lane A (port 1) and lane B (port 2) bytes are streamed in lockstep.
// A two-word prefetch (current + next register) keeps the stream free of
// bubbles for BRAM_LAT of 1 or 2.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle launch pulse (honoured only in IDLE)
//   base_addr          first word address, captured on start
//   word_cnt           number of words to read, captured on start
//   en_BRAM32k         read enable shared by both BRAM ports
//   addr_BRAM32k_1/_2  read address, identical on both ports
//   dout_BRAM32k_1/_2  read data, valid BRAM_LAT cycles after en_BRAM32k
//   out_valid          byteA/byteB/byte_idx/last are valid
//   out_ready          consumer accepts the current byte pair
//   byteA, byteB       raw signed bytes from lane A / lane B
//   byte_idx           position (0..7) of the pair within its word
//   last               pair is byte 7 of the final word
//   busy               transfer in progress
//   done               one-cycle completion pulse
//
// Handshake: a pair transfers on every rising clk edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// byteA, byteB, byte_idx and last hold stable and out_valid stays high.
// out_valid never depends combinationally on out_ready.

module bram32k_reader #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 64,
    parameter int BRAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_cnt,
    output logic              en_BRAM32k,
    output logic [ADDR_W-1:0] addr_BRAM32k_1,
    output logic [ADDR_W-1:0] addr_BRAM32k_2,
    input  logic [DATA_W-1:0] dout_BRAM32k_1,
    input  logic [DATA_W-1:0] dout_BRAM32k_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        byteA,
    output logic [7:0]        byteB,
    output logic [2:0]        byte_idx,
    output logic              last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } stateT;

    stateT               state;
    logic [ADDR_W-1:0]   addrReg;     // address presented with the current/next read
    logic [ADDR_W-1:0]   issueLeft;   // words still to be requested
    logic [ADDR_W-1:0]   outLeft;     // words still to be delivered
    logic                enReg;
    logic                busyReg;
    logic                doneReg;
    logic                curFull;
    logic                nxtFull;
    logic [DATA_W-1:0]   cur1;
    logic [DATA_W-1:0]   cur2;
    logic [DATA_W-1:0]   nxt1;
    logic [DATA_W-1:0]   nxt2;
    logic [2:0]          byteIdx;
    logic [BRAM_LAT-1:0] tagPipe;     // bit k set: a read issued k+1 cycles ago
    logic [BRAM_LAT-1:0] tagNext;
    logic [2:0]          pendCnt;     // words held + reads in flight
    logic                arrive;
    logic                accept;
    logic                pop;
    logic                issue;

    always_comb begin
        tagNext    = tagPipe << 1;
        tagNext[0] = enReg;
    end

    always_comb begin
        pendCnt = {2'b00, curFull} + {2'b00, nxtFull} + {2'b00, enReg};
        for (int i = 0; i < BRAM_LAT; i++) begin
            pendCnt = pendCnt + {2'b00, tagPipe[i]};
        end
    end

    // The oldest tag marks the cycle in which dout carries the requested word.
    assign arrive = tagPipe[BRAM_LAT-1];
    assign accept = curFull && out_ready;
    assign pop    = accept && (byteIdx == 3'd7);

    // A word leaving at this edge is not credited, so the held + in-flight
    // total can never exceed two. The prefetch slack still covers BRAM_LAT=2.
    assign issue  = (state == RUN) && (issueLeft != '0) && (pendCnt < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addrReg   <= '0;
            issueLeft <= '0;
            outLeft   <= '0;
            enReg     <= 1'b0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            curFull   <= 1'b0;
            nxtFull   <= 1'b0;
            cur1      <= '0;
            cur2      <= '0;
            nxt1      <= '0;
            nxt2      <= '0;
            byteIdx   <= 3'd0;
            tagPipe   <= '0;
        end else begin
            enReg   <= 1'b0;
            tagPipe <= tagNext;

            // Address advances after each issued read; wraps naturally.
            if (enReg) begin
                addrReg <= addrReg + ADDR_W'(1);
            end

            if (accept) begin
                byteIdx <= byteIdx + 3'd1;
            end

            // Word buffers: a pop moves next into current, and a word arriving
            // in the same cycle drops into whichever slot is free afterwards.
            if (pop) begin
                if (nxtFull) begin
                    cur1    <= nxt1;
                    cur2    <= nxt2;
                    nxtFull <= arrive;
                    if (arrive) begin
                        nxt1 <= dout_BRAM32k_1;
                        nxt2 <= dout_BRAM32k_2;
                    end
                end else begin
                    curFull <= arrive;
                    if (arrive) begin
                        cur1 <= dout_BRAM32k_1;
                        cur2 <= dout_BRAM32k_2;
                    end
                end
            end else if (arrive) begin
                if (!curFull) begin
                    curFull <= 1'b1;
                    cur1    <= dout_BRAM32k_1;
                    cur2    <= dout_BRAM32k_2;
                end else begin
                    nxtFull <= 1'b1;
                    nxt1    <= dout_BRAM32k_1;
                    nxt2    <= dout_BRAM32k_2;
                end
            end

            case (state)
                IDLE: begin
                    doneReg <= 1'b0;
                    if (start) begin
                        addrReg   <= base_addr;
                        issueLeft <= word_cnt;
                        outLeft   <= word_cnt;
                        byteIdx   <= 3'd0;
                        busyReg   <= 1'b1;
                        if (word_cnt == '0) begin
                            // Empty transfer: busy and done share one cycle.
                            state   <= ZERO;
                            doneReg <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                ZERO: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                    doneReg <= 1'b0;
                end
                RUN: begin
                    if (issue) begin
                        enReg     <= 1'b1;
                        issueLeft <= issueLeft - ADDR_W'(1);
                    end
                    if (pop) begin
                        outLeft <= outLeft - ADDR_W'(1);
                        if (outLeft == ADDR_W'(1)) begin
                            state   <= FIN;
                            busyReg <= 1'b0;
                            doneReg <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state   <= IDLE;
                    doneReg <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte select assumes an 8-byte word: index = byte_idx * 8.
    assign byteA          = cur1[{byteIdx, 3'b000} +: 8];
    assign byteB          = cur2[{byteIdx, 3'b000} +: 8];
    assign byte_idx       = byteIdx;
    assign out_valid      = curFull;
    assign last           = curFull && (byteIdx == 3'd7) && (outLeft == ADDR_W'(1));
    assign en_BRAM32k     = enReg;
    assign addr_BRAM32k_1 = addrReg;
    assign addr_BRAM32k_2 = addrReg;
    assign busy           = busyReg;
    assign done           = doneReg;

endmodule

// File: tb/tb_bram32k_reader.sv
// Bench for bram32k_reader: two instances (BRAM_LAT = 1 and 2) see the same
// stimulus and the same memory contents. A reference model expands each
// transfer into its expected byte pairs and read addresses; a monitor pops
// and compares whenever an instance presents a pair or issues a read.

module tb_bram32k_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] baseAddr;
  logic [11:0] wordCnt;
  logic        outReady;

  logic        en       [2];
  logic [11:0] addr1    [2];
  logic [11:0] addr2    [2];
  logic        outValid [2];
  logic [7:0]  byteA    [2];
  logic [7:0]  byteB    [2];
  logic [2:0]  byteIdx  [2];
  logic        last     [2];
  logic        busy     [2];
  logic        done     [2];

  logic [63:0] dA0, dB0, dA1, dB1, sA1, sB1;

  logic [63:0] mem1 [4096];
  logic [63:0] mem2 [4096];

  // {last, idx[2:0], byteA, byteB}
  logic [19:0] expQ0[$];
  logic [19:0] expQ1[$];
  logic [11:0] addrQ0[$];
  logic [11:0] addrQ1[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int enCnt    [2];
  int doneCnt  [2];
  int busyCnt  [2];
  int gaps     [2];
  int accepted [2];
  int issued   [2];
  int wordsDone[2];
  bit stallPrev[2];
  bit lastPrev [2];
  bit inStream [2];

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- DUTs ----------------
  bram32k_reader #(.ADDR_W(12), .DATA_W(64), .BRAM_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .base_addr(baseAddr), .word_cnt(wordCnt),
    .en_BRAM32k(en[0]), .addr_BRAM32k_1(addr1[0]), .addr_BRAM32k_2(addr2[0]),
    .dout_BRAM32k_1(dA0), .dout_BRAM32k_2(dB0),
    .out_valid(outValid[0]), .out_ready(outReady),
    .byteA(byteA[0]), .byteB(byteB[0]), .byte_idx(byteIdx[0]),
    .last(last[0]), .busy(busy[0]), .done(done[0])
  );

  bram32k_reader #(.ADDR_W(12), .DATA_W(64), .BRAM_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .base_addr(baseAddr), .word_cnt(wordCnt),
    .en_BRAM32k(en[1]), .addr_BRAM32k_1(addr1[1]), .addr_BRAM32k_2(addr2[1]),
    .dout_BRAM32k_1(dA1), .dout_BRAM32k_2(dB1),
    .out_valid(outValid[1]), .out_ready(outReady),
    .byteA(byteA[1]), .byteB(byteB[1]), .byte_idx(byteIdx[1]),
    .last(last[1]), .busy(busy[1]), .done(done[1])
  );

  // ---------------- BRAM models (garbage when not enabled) ----------------
  always @(posedge clk) begin
    dA0 <= en[0] ? mem1[addr1[0]] : {$urandom, $urandom};
    dB0 <= en[0] ? mem2[addr2[0]] : {$urandom, $urandom};
  end

  always @(posedge clk) begin
    sA1 <= en[1] ? mem1[addr1[1]] : {$urandom, $urandom};
    sB1 <= en[1] ? mem2[addr2[1]] : {$urandom, $urandom};
    dA1 <= sA1;
    dB1 <= sB1;
  end

  // ---------------- watchdog ----------------
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a transfer is cnt words from base (mod 4096), each
  // emitted as eight byte pairs, byte 0 first; last marks byte 7 of word cnt-1.
  task automatic pushTransfer(input int base, input int cnt);
    int a;
    logic [19:0] item;
    for (int w = 0; w < cnt; w++) begin
      a = (base + w) % 4096;
      addrQ0.push_back(12'(a));
      addrQ1.push_back(12'(a));
      for (int b = 0; b < 8; b++) begin
        item = {((w == cnt - 1) && (b == 7)) ? 1'b1 : 1'b0, 3'(b),
                mem1[a][8*b +: 8], mem2[a][8*b +: 8]};
        expQ0.push_back(item);
        expQ1.push_back(item);
      end
    end
  endtask

  task automatic monitorLane(input int l);
    logic [19:0] got;
    logic [19:0] want;
    logic [11:0] wantAddr;
    int qs;
    int as;
    if (lastPrev[l]) begin
      check($sformatf("lane%0d_done_after_last", l), 64'(done[l]), 64'(1));
      lastPrev[l] = 1'b0;
    end
    if (en[l]) begin
      enCnt[l]++;
      issued[l]++;
      as = (l == 0) ? addrQ0.size() : addrQ1.size();
      if (as == 0) begin
        total++;
        bad++;
        $display("FAIL lane%0d_extra_read: got addr %0h expected no read", l, addr1[l]);
      end else begin
        if (l == 0) wantAddr = addrQ0.pop_front();
        else        wantAddr = addrQ1.pop_front();
        check($sformatf("lane%0d_rd_addr1", l), 64'(addr1[l]), 64'(wantAddr));
        check($sformatf("lane%0d_rd_addr2", l), 64'(addr2[l]), 64'(wantAddr));
      end
      check($sformatf("lane%0d_outstanding_le2", l),
            64'((issued[l] - wordsDone[l]) <= 2), 64'(1));
    end
    if (stallPrev[l]) begin
      check($sformatf("lane%0d_stall_hold_valid", l), 64'(outValid[l]), 64'(1));
    end
    if (outValid[l]) begin
      inStream[l] = 1'b1;
      qs = (l == 0) ? expQ0.size() : expQ1.size();
      got = {last[l], byteIdx[l], byteA[l], byteB[l]};
      if (qs == 0) begin
        total++;
        bad++;
        $display("FAIL lane%0d_unexpected_valid: got pair %0h expected none", l, got);
      end else begin
        want = (l == 0) ? expQ0[0] : expQ1[0];
        check($sformatf("lane%0d_pair", l), 64'(got), 64'(want));
        if (outReady) begin
          if (l == 0) void'(expQ0.pop_front());
          else        void'(expQ1.pop_front());
          accepted[l]++;
          if (want[18:16] == 3'd7) wordsDone[l]++;
          if (want[19]) begin
            lastPrev[l] = 1'b1;
            inStream[l] = 1'b0;
          end
        end
      end
    end else if (inStream[l]) begin
      gaps[l]++;
    end
    stallPrev[l] = outValid[l] && !outReady;
    if (done[l]) doneCnt[l]++;
    if (busy[l]) busyCnt[l]++;
  endtask

  task automatic checkIdleOutputs(input string tag);
    for (int l = 0; l < 2; l++) begin
      check($sformatf("%s_lane%0d_valid", tag, l), 64'(outValid[l]), 64'(0));
      check($sformatf("%s_lane%0d_en", tag, l), 64'(en[l]), 64'(0));
      check($sformatf("%s_lane%0d_addr1", tag, l), 64'(addr1[l]), 64'(0));
      check($sformatf("%s_lane%0d_addr2", tag, l), 64'(addr2[l]), 64'(0));
      check($sformatf("%s_lane%0d_byteA", tag, l), 64'(byteA[l]), 64'(0));
      check($sformatf("%s_lane%0d_byteB", tag, l), 64'(byteB[l]), 64'(0));
      check($sformatf("%s_lane%0d_idx", tag, l), 64'(byteIdx[l]), 64'(0));
      check($sformatf("%s_lane%0d_last", tag, l), 64'(last[l]), 64'(0));
      check($sformatf("%s_lane%0d_busy", tag, l), 64'(busy[l]), 64'(0));
      check($sformatf("%s_lane%0d_done", tag, l), 64'(done[l]), 64'(0));
    end
  endtask

  // Drives one transfer to completion on both instances and checks totals.
  task automatic runTransfer(input string tag, input int base, input int cnt,
                             input bit randReady, input bit noGaps, input bit pokeBusy);
    int e0, e1, g0, g1, d0, d1, n;
    bit fin;
    e0 = enCnt[0];   e1 = enCnt[1];
    g0 = gaps[0];    g1 = gaps[1];
    d0 = doneCnt[0]; d1 = doneCnt[1];
    @(posedge clk); #1;
    outReady = 1'b1;
    baseAddr = 12'(base);
    wordCnt  = 12'(cnt);
    start    = 1'b1;
    pushTransfer(base, cnt);
    @(posedge clk); #1;
    start = 1'b0;
    if (randReady) outReady = 1'($urandom_range(0, 1));
    n = 0;
    fin = 1'b0;
    while (!fin && n < 1000) begin
      if (pokeBusy && n == 3) begin
        baseAddr = 12'(base + 100);
        wordCnt  = 12'd5;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (randReady) outReady = 1'($urandom_range(0, 1));
      fin = (doneCnt[0] != d0) && (doneCnt[1] != d1);
    end
    start    = 1'b0;
    outReady = 1'b1;
    check({tag, "_completes"}, 64'(fin), 64'(1));
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_lane0_pairs_left"}, 64'(expQ0.size()), 64'(0));
    check({tag, "_lane1_pairs_left"}, 64'(expQ1.size()), 64'(0));
    check({tag, "_lane0_reads_left"}, 64'(addrQ0.size()), 64'(0));
    check({tag, "_lane1_reads_left"}, 64'(addrQ1.size()), 64'(0));
    check({tag, "_lane0_read_count"}, 64'(enCnt[0] - e0), 64'(cnt));
    check({tag, "_lane1_read_count"}, 64'(enCnt[1] - e1), 64'(cnt));
    check({tag, "_lane0_done_count"}, 64'(doneCnt[0] - d0), 64'(1));
    check({tag, "_lane1_done_count"}, 64'(doneCnt[1] - d1), 64'(1));
    if (noGaps) begin
      check({tag, "_lane0_gaps"}, 64'(gaps[0] - g0), 64'(0));
      check({tag, "_lane1_gaps"}, 64'(gaps[1] - g1), 64'(0));
    end
  endtask

  task automatic runTests();
    int b0, b1, snapA, n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst = 1'b0;

    // Single word, known pattern
    mem1[16] = 64'h8807_0605_0403_0201;
    runTransfer("one_word", 12'h010, 1, 1'b0, 1'b1, 1'b0);

    // Four words, streaming without stalls
    runTransfer("four_words", 12'h100, 4, 1'b0, 1'b1, 1'b0);

    // Random backpressure
    runTransfer("stall3", int'($urandom_range(0, 4095)), 3, 1'b1, 1'b0, 1'b0);

    // Address wrap
    runTransfer("wrap", 12'hFFE, 3, 1'b0, 1'b1, 1'b0);

    // Zero-length transfer
    b0 = busyCnt[0];
    b1 = busyCnt[1];
    runTransfer("zero", 12'h123, 0, 1'b0, 1'b1, 1'b0);
    check("zero_lane0_busy_cycles", 64'(busyCnt[0] - b0), 64'(1));
    check("zero_lane1_busy_cycles", 64'(busyCnt[1] - b1), 64'(1));

    // Random transfers
    for (int k = 0; k < 4; k++) begin
      runTransfer($sformatf("rand%0d", k), int'($urandom_range(0, 4095)),
                  int'($urandom_range(1, 6)), 1'b1, 1'b0, 1'b0);
    end

    // Reset in the middle of word 1 of a two-word transfer
    snapA = accepted[0];
    @(posedge clk); #1;
    outReady = 1'b1;
    baseAddr = 12'h200;
    wordCnt  = 12'd2;
    start    = 1'b1;
    pushTransfer(12'h200, 2);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while ((accepted[0] - snapA) < 12 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_reset_reached_word1_byte3", 64'((accepted[0] - snapA) >= 12), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    checkIdleOutputs("mid_reset");
    expQ0.delete();
    expQ1.delete();
    addrQ0.delete();
    addrQ1.delete();
    for (int l = 0; l < 2; l++) begin
      issued[l]    = 0;
      wordsDone[l] = 0;
    end
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      check($sformatf("post_reset_lane%0d_quiet_valid", l), 64'(outValid[l]), 64'(0));
      check($sformatf("post_reset_lane%0d_quiet_busy", l), 64'(busy[l]), 64'(0));
    end

    // Fresh transfer, with an ignored start pulse while busy
    runTransfer("after_reset", int'($urandom_range(0, 4095)), 2, 1'b0, 1'b1, 1'b1);
  endtask

  // ---------------- main: stimulus and monitor ----------------
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    baseAddr = 12'h000;
    wordCnt  = 12'h000;
    outReady = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      mem1[i] = {$urandom, $urandom};
      mem2[i] = {$urandom, $urandom};
    end
    for (int l = 0; l < 2; l++) begin
      enCnt[l] = 0; doneCnt[l] = 0; busyCnt[l] = 0; gaps[l] = 0;
      accepted[l] = 0; issued[l] = 0; wordsDone[l] = 0;
      stallPrev[l] = 1'b0; lastPrev[l] = 1'b0; inStream[l] = 1'b0;
    end
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
          for (int l = 0; l < 2; l++) begin
            stallPrev[l] = 1'b0;
            lastPrev[l]  = 1'b0;
            inStream[l]  = 1'b0;
          end
        end else begin
          monitorLane(0);
          monitorLane(1);
        end
      end
      begin
        runTests();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join
  end

endmodule
